spi_rdid_responder: RTL
=======================

# spi_rdid_responder

Synthesizable SPI flash responder that answers the JEDEC Read-Identification command (0x9F) with a three-byte ID, acting as the far end of the board's SPI master. It oversamples SPICLK, SPIMOSI and the active-low chip select in the system clock domain and drives SPIMISO, giving the command and LCD layers a deterministic in-FPGA flash stand-in for bring-up and loopback testing. Any other opcode is reported on status outputs and otherwise ignored until chip select deasserts.

## Interface
- MFG_ID, 8'h20, manufacturer ID byte, sent first
- MEM_TYPE, 8'h20, memory type byte, sent second
- MEM_CAP, 8'h15, memory capacity byte, sent third
- RDID_OPCODE, 8'h9F, opcode that triggers the ID response

- clk  in  1  system clock; one clock only
- reset_n  in  1  reset, asynchronous, active-low
- SPICLK  in  1  SPI clock from master, asynchronous to clk; mode 0
- SPIMOSI  in  1  serial data from master
- chip_select  in  1  active-low select from master
- SPIMISO  out  1  serial data to master
- SPIMISO_oe  out  1  high while a response is being driven
- cmd_byte  out  8  last complete opcode received
- cmd_valid  out  1  one-cycle pulse when cmd_byte updates
- busy  out  1  high while chip_select is asserted (synchronized)
- rdid_done  out  1  one-cycle pulse after the 24th response bit is sampled

## Operation
- SPICLK, SPIMOSI, chip_select each pass a 2-flop synchronizer; a third flop on SPICLK and chip_select gives rise/fall edge detection.
- States: IDLE, CMD, RESP, DRAIN.
- IDLE: SPIMISO=0, SPIMISO_oe=0. Synchronized chip_select low -> CMD, bit counter=0.
- CMD: on each SPICLK rise, shift synchronized SPIMOSI into cmd shifter MSB-first, counter+1. On 8th rise: cmd_byte<=shifted byte, cmd_valid pulse. If byte==RDID_OPCODE -> RESP, load 24-bit shifter {MFG_ID,MEM_TYPE,MEM_CAP}, SPIMISO<=bit 23, SPIMISO_oe<=1, counter=0. Else -> DRAIN.
- RESP: each SPICLK fall shifts response left, SPIMISO<=new bit 23. Each SPICLK rise counts a sampled bit; on 24th rise -> DRAIN, rdid_done pulse.
- DRAIN: SPIMISO=0, SPIMISO_oe=0; ignore SPICLK until chip_select high.
- Any state: synchronized chip_select rise -> IDLE next cycle, counters cleared, SPIMISO=0, oe=0. This takes priority over a same-cycle SPICLK edge.
- Fewer than 8 SPICLK rises before chip_select rise: no cmd_valid, cmd_byte unchanged.
- Counter width 5 bits; never wraps (state exits at 8 and 24).

## Timing
- Reset values: state IDLE, SPIMISO 0, SPIMISO_oe 0, cmd_byte 8'h00, cmd_valid 0, busy 0, rdid_done 0, all shifters/counters 0.
- clk must be >= 8x SPICLK frequency; SPICLK high and low phases each >= 4 clk periods.
- Input-edge-to-action latency: 3 clk cycles (2 sync + 1 edge detect); registered outputs change on the following edge (SPIMISO updates 3-4 clk after SPICLK fall).
- First response bit is valid before the 8th SPICLK fall, i.e. well ahead of the 9th rise.
- busy follows chip_select with 2-cycle latency.
- cmd_valid and rdid_done are exactly one clk wide.

## Structure
- Shared package/header: RDID opcode 8'h9F, default ID bytes, state encodings (3-bit localparams idle/cmd/resp/drain, matching existing state-machine style).
- One sub-module: reuse existing `sync` for the three 2-flop synchronizers; edge detection and FSM stay in this module.
- Simulation-only ASCII state annotation (16-char names) for waveforms.

## Test plan
- Reset mid-RESP (reset_n low after 10 response bits) -> all outputs at reset values immediately; next 0x9F transaction returns 0x20 0x20 0x15 intact.
- Send 0x9F, clock 24 more bits at clk/10 -> master reads 0x20, 0x20, 0x15; cmd_byte=0x9F; cmd_valid and rdid_done one pulse each.
- Send 0x05 then 16 clocks -> cmd_byte=0x05, SPIMISO_oe never high, no rdid_done.
- Raise chip_select after 5 bits -> no cmd_valid, state IDLE within 3 cycles, cmd_byte unchanged.
- 0x9F with 40 response clocks -> bits 25-40 read 0, oe low after bit 24.
- Parameter override MFG_ID=8'hEF, MEM_TYPE=8'h40, MEM_CAP=8'h18 -> master reads 0xEF 0x40 0x18.

Source files
------------

// File: rtl/spi_rdid_responder_pkg.sv
// Shared constants for the SPI RDID responder: opcode, default JEDEC ID bytes,
// state encodings and a waveform-friendly state name helper.
package spi_rdid_responder_pkg;

  localparam logic [7:0] DEF_RDID_OPCODE = 8'h9F;
  localparam logic [7:0] DEF_MFG_ID      = 8'h20;
  localparam logic [7:0] DEF_MEM_TYPE    = 8'h20;
  localparam logic [7:0] DEF_MEM_CAP     = 8'h15;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_RESP  = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    CMD   = ST_CMD,
    RESP  = ST_RESP,
    DRAIN = ST_DRAIN
  } state_e;

  localparam logic [4:0] CMD_LAST_BIT  = 5'd7;
  localparam logic [4:0] RESP_LAST_BIT = 5'd23;

  function automatic logic [127:0] state_name(input state_e s);
    case (s)
      IDLE:    return "IDLE            ";
      CMD:     return "CMD             ";
      RESP:    return "RESP            ";
      DRAIN:   return "DRAIN           ";
      default: return "UNKNOWN         ";
    endcase
  endfunction

endpackage

// File: rtl/spi_rdid_responder_if.sv
// SPI pins plus status outputs of the RDID responder; the board master drives
// the SPI inputs, the responder drives everything else.
interface spi_rdid_responder_if;

  logic         SPICLK;
  logic         SPIMOSI;
  logic         chip_select;
  logic         SPIMISO;
  logic         SPIMISO_oe;
  logic [7:0]   cmd_byte;
  logic         cmd_valid;
  logic         busy;
  logic         rdid_done;
  logic [127:0] state_ascii;

  modport master (
    output SPICLK, SPIMOSI, chip_select,
    input  SPIMISO, SPIMISO_oe, cmd_byte, cmd_valid, busy, rdid_done, state_ascii
  );

  modport slave (
    input  SPICLK, SPIMOSI, chip_select,
    output SPIMISO, SPIMISO_oe, cmd_byte, cmd_valid, busy, rdid_done, state_ascii
  );

endinterface

// File: rtl/spi_rdid_responder_sync.sv
// Plain 2-flop synchronizer, one per bit, with a per-bit reset value so an
// active-low input can come out of reset deasserted.
module spi_rdid_responder_sync #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spi_rdid_responder.sv
// SPI mode-0 flash stand-in answering JEDEC RDID (0x9F) with a 3-byte ID;
// SPI pins are oversampled in clk, other opcodes are reported then ignored.
module spi_rdid_responder
  import spi_rdid_responder_pkg::*;
#(
  parameter logic [7:0] MFG_ID      = DEF_MFG_ID,
  parameter logic [7:0] MEM_TYPE    = DEF_MEM_TYPE,
  parameter logic [7:0] MEM_CAP     = DEF_MEM_CAP,
  parameter logic [7:0] RDID_OPCODE = DEF_RDID_OPCODE
) (
  input logic                 clk,
  input logic                 reset_n,
  spi_rdid_responder_if.slave bus
);

  localparam logic [23:0] ID_WORD = {MFG_ID, MEM_TYPE, MEM_CAP};

  logic [2:0] pins_sync;
  logic       sclk_s, mosi_s, csn_s;
  logic       sclk_q, csn_q;
  logic       sclk_rise, sclk_fall, cs_rise;

  // chip_select resets high so busy and the FSM see a deselected bus.
  spi_rdid_responder_sync #(.WIDTH(3), .RST_VAL(3'b100)) u_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   ({bus.chip_select, bus.SPIMOSI, bus.SPICLK}),
    .q_o   (pins_sync)
  );

  assign sclk_s = pins_sync[0];
  assign mosi_s = pins_sync[1];
  assign csn_s  = pins_sync[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q <= 1'b0;
      csn_q  <= 1'b1;
    end else begin
      sclk_q <= sclk_s;
      csn_q  <= csn_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_rise   = csn_s & ~csn_q;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  cmd_sh_q, cmd_sh_d, cmd_next;
  logic [23:0] resp_sh_q, resp_sh_d;
  logic        miso_q, miso_d;
  logic        oe_q, oe_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic        rdid_done_q, rdid_done_d;

  assign cmd_next = (cmd_sh_q << 1) | {7'b0, mosi_s};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_sh_q    <= '0;
      resp_sh_q   <= '0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      cmd_byte_q  <= '0;
      cmd_valid_q <= 1'b0;
      rdid_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_sh_q    <= cmd_sh_d;
      resp_sh_q   <= resp_sh_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      cmd_byte_q  <= cmd_byte_d;
      cmd_valid_q <= cmd_valid_d;
      rdid_done_q <= rdid_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_sh_d    = cmd_sh_q;
    resp_sh_d   = resp_sh_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    cmd_byte_d  = cmd_byte_q;
    cmd_valid_d = 1'b0;
    rdid_done_d = 1'b0;
    if (cs_rise) begin
      state_d   = IDLE;
      cnt_d     = '0;
      cmd_sh_d  = '0;
      resp_sh_d = '0;
      miso_d    = 1'b0;
      oe_d      = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          oe_d   = 1'b0;
          if (!csn_s) begin
            state_d = CMD;
            cnt_d   = '0;
          end
        end
        CMD: begin
          if (sclk_rise) begin
            cmd_sh_d = cmd_next;
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == CMD_LAST_BIT) begin
              cmd_byte_d  = cmd_next;
              cmd_valid_d = 1'b1;
              cnt_d       = '0;
              if (cmd_next == RDID_OPCODE) begin
                state_d   = RESP;
                resp_sh_d = ID_WORD;
                miso_d    = ID_WORD[23];
                oe_d      = 1'b1;
              end else begin
                state_d = DRAIN;
              end
            end
          end
        end
        RESP: begin
          // The fall right after the opcode must keep the first ID bit on
          // the wire until the master samples it, so shift only once a bit
          // has been taken.
          if (sclk_fall && (cnt_q != 5'd0)) begin
            resp_sh_d = resp_sh_q << 1;
            miso_d    = resp_sh_d[23];
          end
          if (sclk_rise) begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == RESP_LAST_BIT) begin
              state_d     = DRAIN;
              rdid_done_d = 1'b1;
              miso_d      = 1'b0;
              oe_d        = 1'b0;
              cnt_d       = '0;
            end
          end
        end
        DRAIN: begin
          miso_d = 1'b0;
          oe_d   = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.SPIMISO    = miso_q;
  assign bus.SPIMISO_oe = oe_q;
  assign bus.cmd_byte   = cmd_byte_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.rdid_done  = rdid_done_q;
  assign bus.busy       = ~csn_s;

`ifndef SYNTHESIS
  assign bus.state_ascii = state_name(state_q);
`else
  assign bus.state_ascii = '0;
`endif

endmodule
